// File: rtl/act_unload_reader.sv
// act_unload_reader
// Streams a finished feature map back out of SRAM group A or B, one
// activation per valid/ready handshake, in channel-major raster order
// (c outer, then y, then x). Each SRAM word holds a 2x2 tile of 4 channels.
// Build option: define UNLOAD_CHECKSUM_EN to add a 16-bit running sum of
// every handshaken byte on the checksum output.
module act_unload_reader #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 8,
    parameter int MAP_W        = 12,
    parameter int MAP_H        = 12
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      sel_b,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a3,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_b3,
    output logic [5:0]                                sram_raddr_a0,
    output logic [5:0]                                sram_raddr_a1,
    output logic [5:0]                                sram_raddr_a2,
    output logic [5:0]                                sram_raddr_a3,
    output logic [5:0]                                sram_raddr_b0,
    output logic [5:0]                                sram_raddr_b1,
    output logic [5:0]                                sram_raddr_b2,
    output logic [5:0]                                sram_raddr_b3,
    output logic [BW_PER_ACT-1:0]                     out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      busy,
    output logic                                      done
`ifdef UNLOAD_CHECKSUM_EN
    ,
    output logic [15:0]                               checksum
`endif
);

    localparam int WORD_W        = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int ADDR_W        = 6;
    localparam int XW            = $clog2(MAP_W);
    localparam int YW            = $clog2(MAP_H);
    localparam int CW            = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int TILES_PER_ROW = MAP_W / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_OUT0,
        S_OUT1,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    sel_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    out_valid_q;
    logic [BW_PER_ACT-1:0]   out_data_q;
    logic [WORD_W-1:0]       hold_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [CW-1:0]           c_q;
    logic [ADDR_W-1:0]       raddr_a_q [4];
    logic [ADDR_W-1:0]       raddr_b_q [4];

    logic [XW-1:0]           x_d;
    logic [YW-1:0]           y_d;
    logic [CW-1:0]           c_d;
    logic [1:0]              bank_d;
    logic [ADDR_W-1:0]       addr_d;
    logic                    last_pair;
    logic [1:0]              cur_bank;
    logic [WORD_W-1:0]       rdata_sel;

    // Byte lane of activation (c, y%2, x%2) inside a packed tile word;
    // channel 0, top-left pixel lives in the most significant byte.
    function automatic logic [BW_PER_ACT-1:0] pick_byte(
        input logic [WORD_W-1:0] word,
        input logic [CW-1:0]     c,
        input logic              y_odd,
        input logic              x_odd
    );
        int k;
        k = CH_NUM * ACT_PER_ADDR - 1
            - (int'(c) * ACT_PER_ADDR + int'(y_odd) * 2 + int'(x_odd));
        return word[k*BW_PER_ACT +: BW_PER_ACT];
    endfunction

    // Word address of the 2x2 tile holding (y, x): tiles alternate across
    // the four banks, so each bank address covers a 4x4 pixel block.
    function automatic logic [ADDR_W-1:0] tile_addr(
        input logic [YW-1:0] y,
        input logic [XW-1:0] x
    );
        return ADDR_W'((int'(y) / 4) * TILES_PER_ROW + int'(x) / 4);
    endfunction

    // Bank of the current tile: (ty%2)*2 + (tx%2) with ty=y/2, tx=x/2.
    assign cur_bank = {y_q[1], x_q[1]};

    // Select the read word of the bank addressed in the previous cycle.
    always_comb begin
        rdata_sel = '0;
        case ({sel_q, cur_bank})
            3'b000:  rdata_sel = sram_rdata_a0;
            3'b001:  rdata_sel = sram_rdata_a1;
            3'b010:  rdata_sel = sram_rdata_a2;
            3'b011:  rdata_sel = sram_rdata_a3;
            3'b100:  rdata_sel = sram_rdata_b0;
            3'b101:  rdata_sel = sram_rdata_b1;
            3'b110:  rdata_sel = sram_rdata_b2;
            default: rdata_sel = sram_rdata_b3;
        endcase
    end

    // Next x pair position in raster order and the tile address it needs.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        last_pair = 1'b0;
        if (x_q == XW'(MAP_W - 2)) begin
            x_d = '0;
            if (y_q == YW'(MAP_H - 1)) begin
                y_d = '0;
                c_d = c_q + 1'b1;
                if (c_q == CW'(CH_NUM - 1)) begin
                    last_pair = 1'b1;
                end
            end else begin
                y_d = y_q + 1'b1;
            end
        end else begin
            x_d = x_q + XW'(2);
        end
        bank_d = {y_d[1], x_d[1]};
        addr_d = tile_addr(y_d, x_d);
    end

    // Control FSM: sequencing, counters, addresses and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            raddr_a_q   <= '{default: '0};
            raddr_b_q   <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sel_q     <= sel_b;
                        busy_q    <= 1'b1;
                        x_q       <= '0;
                        y_q       <= '0;
                        c_q       <= '0;
                        // Pixel (0,0) is bank 0, address 0 in either group.
                        raddr_a_q <= '{default: '0};
                        raddr_b_q <= '{default: '0};
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    out_data_q  <= pick_byte(rdata_sel, c_q, y_q[0], 1'b0);
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT0;
                end
                S_OUT0: begin
                    if (out_ready) begin
                        out_data_q <= pick_byte(hold_q, c_q, y_q[0], 1'b1);
                        state_q    <= S_OUT1;
                    end
                end
                S_OUT1: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_pair) begin
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            raddr_a_q <= '{default: '0};
                            raddr_b_q <= '{default: '0};
                            state_q   <= S_DONE;
                        end else begin
                            x_q <= x_d;
                            y_q <= y_d;
                            c_q <= c_d;
                            for (int b = 0; b < 4; b++) begin
                                raddr_a_q[b] <= (!sel_q && (int'(bank_d) == b)) ? addr_d : '0;
                                raddr_b_q[b] <= ( sel_q && (int'(bank_d) == b)) ? addr_d : '0;
                            end
                            state_q <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Word hold register: keeps the tile so the odd-x byte needs no re-read.
    always_ff @(posedge clk) begin
        if (state_q == S_LAT) begin
            hold_q <= rdata_sel;
        end
    end

`ifdef UNLOAD_CHECKSUM_EN
    logic [15:0] csum_q;

    // Running modulo-2^16 sum of accepted bytes, restarted per unload.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            csum_q <= '0;
        end else if (out_valid_q && out_ready) begin
            csum_q <= csum_q + 16'(out_data_q);
        end
    end

    assign checksum = csum_q;
`endif

    assign sram_raddr_a0 = raddr_a_q[0];
    assign sram_raddr_a1 = raddr_a_q[1];
    assign sram_raddr_a2 = raddr_a_q[2];
    assign sram_raddr_a3 = raddr_a_q[3];
    assign sram_raddr_b0 = raddr_b_q[0];
    assign sram_raddr_b1 = raddr_b_q[1];
    assign sram_raddr_b2 = raddr_b_q[2];
    assign sram_raddr_b3 = raddr_b_q[3];
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_act_unload_reader.sv
// Testbench for act_unload_reader: SRAM group models with one-cycle read
// latency, a handshake monitor, a layout vector table and directed
// multi-cycle sequences (stall, ignored start, mid-unload reset, checksum).
module tb_act_unload_reader;

    localparam int NACT = 576;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sel_b;
    logic         out_ready;
    logic [127:0] rd_a [4];
    logic [127:0] rd_b [4];
    logic [5:0]   ra_a [4];
    logic [5:0]   ra_b [4];
    logic [7:0]   out_data;
    logic         out_valid;
    logic         busy;
    logic         done;
`ifdef UNLOAD_CHECKSUM_EN
    logic [15:0]  checksum;
`endif

    logic [127:0] mem_a [4][64];
    logic [127:0] mem_b [4][64];

    int         edge_n = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] got[$];
    int         hs_edge[$];
    int         done_cnt = 0;
    int         stall_viol = 0;
    int         stall_cycles = 0;
    int         a_nonzero = 0;
    int         b_nonzero = 0;
    bit         rand_ready = 1'b0;

    typedef struct {
        bit         g;
        int         bank;
        int         addr;
        int         k;
        logic [7:0] v;
        int         idx;
    } vec_t;

    always #5 clk = ~clk;

    act_unload_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sel_b         (sel_b),
        .sram_rdata_a0 (rd_a[0]),
        .sram_rdata_a1 (rd_a[1]),
        .sram_rdata_a2 (rd_a[2]),
        .sram_rdata_a3 (rd_a[3]),
        .sram_rdata_b0 (rd_b[0]),
        .sram_rdata_b1 (rd_b[1]),
        .sram_rdata_b2 (rd_b[2]),
        .sram_rdata_b3 (rd_b[3]),
        .sram_raddr_a0 (ra_a[0]),
        .sram_raddr_a1 (ra_a[1]),
        .sram_raddr_a2 (ra_a[2]),
        .sram_raddr_a3 (ra_a[3]),
        .sram_raddr_b0 (ra_b[0]),
        .sram_raddr_b1 (ra_b[1]),
        .sram_raddr_b2 (ra_b[2]),
        .sram_raddr_b3 (ra_b[3]),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
`ifdef UNLOAD_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    // SRAM models: data appears the cycle after the address.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        for (int b = 0; b < 4; b++) begin
            rd_a[b] <= mem_a[b][ra_a[b]];
            rd_b[b] <= mem_b[b][ra_b[b]];
        end
    end

    // Consumer ready: constant high, or pseudo-random when enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor, sampled mid-cycle: handshakes, done, stall stability, addresses.
    initial begin
        logic       pv;
        logic       pr;
        logic       prst;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; prst = 1'b1; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                hs_edge.push_back(edge_n + 1);
            end
            if (done) done_cnt = done_cnt + 1;
            if (!rst && !prst && pv && !pr) begin
                stall_cycles = stall_cycles + 1;
                if (!out_valid || out_data != pd) stall_viol = stall_viol + 1;
            end
            if ((ra_a[0] | ra_a[1] | ra_a[2] | ra_a[3]) != 6'd0) a_nonzero = a_nonzero + 1;
            if ((ra_b[0] | ra_b[1] | ra_b[2] | ra_b[3]) != 6'd0) b_nonzero = b_nonzero + 1;
            pv = out_valid; pr = out_ready; pd = out_data; prst = rst;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mems();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) begin
                mem_a[b][a] = '0;
                mem_b[b][a] = '0;
            end
    endtask

    // Place activation (c, y, x) of a 12x12x4 map into a group.
    task automatic put_byte(input bit g, input int c, input int y, input int x, input logic [7:0] v);
        int tx, ty, bank, addr, k;
        tx = x / 2; ty = y / 2;
        bank = (ty % 2) * 2 + (tx % 2);
        addr = (ty / 2) * 3 + tx / 2;
        k = 15 - (c * 4 + (y % 2) * 2 + (x % 2));
        if (g) mem_b[bank][addr][k*8 +: 8] = v;
        else   mem_a[bank][addr][k*8 +: 8] = v;
    endtask

    // mode 0: byte = raster index mod 256; mode 1: all 0xFF.
    task automatic fill_map(input bit g, input int mode);
        int n;
        n = 0;
        for (int c = 0; c < 4; c++)
            for (int y = 0; y < 12; y++)
                for (int x = 0; x < 12; x++) begin
                    put_byte(g, c, y, x, (mode == 0) ? 8'(n % 256) : 8'hFF);
                    n = n + 1;
                end
    endtask

    task automatic launch(input bit g, output int e0);
        start = 1'b1;
        sel_b = g;
        e0 = edge_n + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic order_errs(output int errs);
        errs = 0;
        for (int n = 0; n < NACT; n++) begin
            if (n >= got.size()) errs = errs + 1;
            else if (int'(got[n]) != n % 256) errs = errs + 1;
        end
    endtask

    function automatic int got_at(input int n);
        return (n < got.size()) ? int'(got[n]) : -1;
    endfunction

    initial begin
        vec_t vecs[6];
        int   e0;
        bit   ok;
        int   errs;
        int   sum;
        int   d0;

        // (group, bank, addr, byte lane, value, raster index) worked by hand
        vecs[0] = '{1'b0, 1, 0, 15, 8'h5A, 2};    // c0 y0  x2
        vecs[1] = '{1'b1, 1, 0, 14, 8'hA5, 3};    // c0 y0  x3
        vecs[2] = '{1'b0, 0, 0,  9, 8'h33, 156};  // c1 y1  x0
        vecs[3] = '{1'b1, 1, 4,  4, 8'h77, 355};  // c2 y5  x7
        vecs[4] = '{1'b0, 3, 8,  0, 8'hC3, 575};  // c3 y11 x11
        vecs[5] = '{1'b1, 2, 5, 10, 8'h81, 225};  // c1 y6  x9

        rst = 1'b1; start = 1'b0; sel_b = 1'b0;
        clear_mems();
        repeat (3) tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_raddr_a", int'(ra_a[0] | ra_a[1] | ra_a[2] | ra_a[3]), 0);
        check("rst_raddr_b", int'(ra_b[0] | ra_b[1] | ra_b[2] | ra_b[3]), 0);
`ifdef UNLOAD_CHECKSUM_EN
        check("rst_checksum", int'(checksum), 0);
`endif
        rst = 1'b0;
        tick();

        // Full raster unload from group B with ready held high.
        fill_map(1'b1, 0);
        got.delete(); hs_edge.delete();
        a_nonzero = 0; b_nonzero = 0;
        d0 = done_cnt;
        launch(1'b1, e0);
        check("busy_after_start", int'(busy), 1);
        tick();
        check("valid_at_E0p1", int'(out_valid), 0);
        tick();
        check("valid_at_E0p2", int'(out_valid), 1);
        check("first_byte", int'(out_data), 0);
        wait_done(1400, ok);
        check("done_seen", int'(ok), 1);
        check("done_cycle", edge_n, e0 + 1152);
        check("busy_in_done", int'(busy), 0);
        tick();
        check("done_one_cycle", int'(done), 0);
        check("done_count", done_cnt - d0, 1);
        check("hs_total", got.size(), NACT);
        check("first_hs_edge", (hs_edge.size() > 0) ? hs_edge[0] : -1, e0 + 3);
        check("last_hs_edge", (hs_edge.size() >= NACT) ? hs_edge[NACT-1] : -1, e0 + 1152);
        for (int n = 0; n < NACT; n++) check($sformatf("raster_byte%0d", n), got_at(n), n % 256);
        check("group_a_addr_quiet", a_nonzero, 0);
        check("group_b_addr_used", int'(b_nonzero > 0), 1);

        // Layout table: one marked byte per unload must land at its raster index.
        for (int i = 0; i < 6; i++) begin
            clear_mems();
            if (vecs[i].g) mem_b[vecs[i].bank][vecs[i].addr][vecs[i].k*8 +: 8] = vecs[i].v;
            else           mem_a[vecs[i].bank][vecs[i].addr][vecs[i].k*8 +: 8] = vecs[i].v;
            got.delete(); hs_edge.delete();
            launch(vecs[i].g, e0);
            wait_done(1400, ok);
            tick();
            check($sformatf("vec%0d_done", i), int'(ok), 1);
            check($sformatf("vec%0d_count", i), got.size(), NACT);
            check($sformatf("vec%0d_byte", i), got_at(vecs[i].idx), int'(vecs[i].v));
            sum = 0;
            foreach (got[n]) sum = sum + int'(got[n]);
            check($sformatf("vec%0d_sum", i), sum, int'(vecs[i].v));
        end

        // Group A bank 1 address 0 holding bytes 0x0F..0x00 high to low.
        clear_mems();
        mem_a[1][0] = 128'h0F0E0D0C0B0A09080706050403020100;
        got.delete(); hs_edge.delete();
        launch(1'b0, e0);
        wait_done(1400, ok);
        tick();
        check("word_done", int'(ok), 1);
        check("word_c0y0x2", got_at(2), 8'h0F);
        check("word_c0y0x3", got_at(3), 8'h0E);
        check("word_c0y1x2", got_at(14), 8'h0D);
        check("word_c0y1x3", got_at(15), 8'h0C);
        check("word_c1y0x2", got_at(146), 8'h0B);
        check("word_c0y0x0", got_at(0), 8'h00);

        // Random back-pressure, start/sel_b poked mid-unload and during DONE.
        clear_mems();
        fill_map(1'b1, 0);
        got.delete(); hs_edge.delete();
        stall_viol = 0; stall_cycles = 0; a_nonzero = 0;
        d0 = done_cnt;
        rand_ready = 1'b1;
        launch(1'b1, e0);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (i == 150) begin start = 1'b1; sel_b = 1'b0; end
            else if (i == 151) start = 1'b0;
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        check("stall_done", int'(ok), 1);
        start = 1'b1;
        sel_b = 1'b0;
        tick();
        start = 1'b0;
        rand_ready = 1'b0;
        check("start_in_done_ignored", int'(busy), 0);
        repeat (5) tick();
        check("idle_after_done", int'(busy), 0);
        check("stall_done_count", done_cnt - d0, 1);
        check("stall_hs_total", got.size(), NACT);
        order_errs(errs);
        check("stall_order_errors", errs, 0);
        check("stall_stability_errors", stall_viol, 0);
        check("stall_group_a_quiet", a_nonzero, 0);

        // Reset right after handshake 100, then a fresh unload.
        got.delete(); hs_edge.delete();
        d0 = done_cnt;
        launch(1'b1, e0);
        for (int i = 0; i < 800; i++) begin
            tick();
            if (got.size() >= 100) break;
        end
        check("hs_before_reset", got.size(), 100);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_raddr_b", int'(ra_b[0] | ra_b[1] | ra_b[2] | ra_b[3]), 0);
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", int'(busy), 0);
        got.delete(); hs_edge.delete();
        launch(1'b1, e0);
        wait_done(1400, ok);
        tick();
        check("restart_done", int'(ok), 1);
        check("restart_total", got.size(), NACT);
        check("restart_first", got_at(0), 0);
        order_errs(errs);
        check("restart_order_errors", errs, 0);

`ifdef UNLOAD_CHECKSUM_EN
        // All-0xFF map from group A: sum of 576 bytes of 255, modulo 2^16.
        clear_mems();
        fill_map(1'b0, 1);
        launch(1'b0, e0);
        wait_done(1400, ok);
        check("csum_done", int'(ok), 1);
        check("csum_at_done", int'(checksum), (NACT * 255) % 65536);
        repeat (3) tick();
        check("csum_held", int'(checksum), (NACT * 255) % 65536);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
